// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and the score datapath.
// The FINISH encoding (3'b101) is also decoded by high_score_check.
package game_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE      = 3'b000,
        MODE_COUNTDOWN = 3'b010,
        MODE_PLAY      = 3'b011,
        MODE_PAUSE     = 3'b100,
        MODE_FINISH    = 3'b101
    } mode_t;

endpackage

// File: rtl/game_timer.sv
// Loadable tick-driven down-counter. Load has priority; otherwise the count
// steps down on a tick while enabled and holds at zero.
module game_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         tick,
    output logic [W-1:0] cnt,
    output logic         at_one
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, else enabled tick decrement, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_one = (cnt_q == W'(1));

endmodule

// File: rtl/game_mode_ctrl.sv
// Game sequencer: countdown, timed play, pause, finish; owns score and combo.
// Optional build macro: COMBO_BONUS_EN (double score per hit at high combo).
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start; last score still shown
// COUNTDOWN | count_digit runs COUNT_SEC..1 on ticks
// PLAY      | song timer runs; hits/misses update score/combo
// PAUSE     | timer, score and combo frozen
// FINISH    | final score held for high_score_check
module game_mode_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int COMBO_W      = 4,
    parameter int TIME_W       = 8,
    parameter int SONG_TICKS   = 120,
    parameter int COUNT_SEC    = 3,
    parameter int COMBO_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start_p,
    input  logic                pause_p,
    input  logic                hit_p,
    input  logic                miss_p,
    output logic [MODE_W-1:0]   mode,
    output logic [SCORE_W-1:0]  score,
    output logic [COMBO_W-1:0]  combo,
    output logic [3:0]          count_digit,
    output logic [TIME_W-1:0]   time_left,
    output logic                play_active
);

    mode_t              state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic               play_active_q;

    logic               cd_load, cd_en, cd_at_one;
    logic [3:0]         cd_val;
    logic               st_load, st_en, st_at_one;
    logic [TIME_W-1:0]  st_val;

    logic [1:0]         inc;
    logic [SCORE_W:0]   score_sum;

    // Points for a hit; the bonus looks at the combo before this hit.
    always_comb begin
`ifdef COMBO_BONUS_EN
        inc = (combo_q >= COMBO_W'(COMBO_THRESH)) ? 2'd2 : 2'd1;
`else
        inc = 2'd1;
`endif
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(inc);
    end

    // Next-state, timer control and score/combo update.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        combo_d = combo_q;
        cd_load = 1'b0;
        cd_val  = 4'd0;
        cd_en   = 1'b0;
        st_load = 1'b0;
        st_val  = '0;
        st_en   = 1'b0;
        unique case (state_q)
            MODE_IDLE: begin
                if (start_p) begin
                    state_d = MODE_COUNTDOWN;
                    cd_load = 1'b1;
                    cd_val  = 4'(COUNT_SEC);
                end
            end
            MODE_COUNTDOWN: begin
                if (start_p) begin
                    state_d = MODE_IDLE;
                    cd_load = 1'b1;
                end else if (tick) begin
                    cd_en = 1'b1;
                    if (cd_at_one) begin
                        state_d = MODE_PLAY;
                        st_load = 1'b1;
                        st_val  = TIME_W'(SONG_TICKS);
                        score_d = '0;
                        combo_d = '0;
                    end
                end
            end
            MODE_PLAY: begin
                if (start_p) begin
                    state_d = MODE_IDLE;
                    st_load = 1'b1;
                end else if (pause_p) begin
                    state_d = MODE_PAUSE;
                end else begin
                    st_en = 1'b1;
                    if (tick && st_at_one) begin
                        state_d = MODE_FINISH;
                    end
                    if (miss_p) begin
                        combo_d = '0;
                    end else if (hit_p) begin
                        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        if (combo_q != '1) begin
                            combo_d = combo_q + COMBO_W'(1);
                        end
                    end
                end
            end
            MODE_PAUSE: begin
                if (start_p) begin
                    state_d = MODE_IDLE;
                    st_load = 1'b1;
                end else if (pause_p) begin
                    state_d = MODE_PLAY;
                end
            end
            MODE_FINISH: begin
                if (start_p) begin
                    state_d = MODE_IDLE;
                end
            end
            default: begin
                state_d = MODE_IDLE;
            end
        endcase
    end

    // State, score, combo and play flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= MODE_IDLE;
            score_q       <= '0;
            combo_q       <= '0;
            play_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            play_active_q <= (state_d == MODE_PLAY);
        end
    end

    game_timer #(.W(4)) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (cd_load),
        .load_val (cd_val),
        .en       (cd_en),
        .tick     (tick),
        .cnt      (count_digit),
        .at_one   (cd_at_one)
    );

    game_timer #(.W(TIME_W)) u_song (
        .clk      (clk),
        .rst      (rst),
        .load     (st_load),
        .load_val (st_val),
        .en       (st_en),
        .tick     (tick),
        .cnt      (time_left),
        .at_one   (st_at_one)
    );

    assign mode        = state_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign play_active = play_active_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Directed bench for game_mode_ctrl; expectations follow COMBO_BONUS_EN.
module tb_game_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       tick, start_p, pause_p, hit_p, miss_p;
    logic [2:0] mode;
    logic [3:0] score, combo, count_digit;
    logic [7:0] time_left;
    logic       play_active;

    int passed = 0;
    int total  = 0;

`ifdef COMBO_BONUS_EN
    localparam int G2_AFTER5 = 6;
    localparam int G2_FINAL  = 7;
    localparam int G3_SCORE  = 6;
`else
    localparam int G2_AFTER5 = 5;
    localparam int G2_FINAL  = 6;
    localparam int G3_SCORE  = 5;
`endif

    game_mode_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start_p     (start_p),
        .pause_p     (pause_p),
        .hit_p       (hit_p),
        .miss_p      (miss_p),
        .mode        (mode),
        .score       (score),
        .combo       (combo),
        .count_digit (count_digit),
        .time_left   (time_left),
        .play_active (play_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock with the given 1-cycle strobes; returns 1 time unit after the edge.
    task automatic step(input logic t, input logic s, input logic p, input logic h, input logic m);
        tick = t; start_p = s; pause_p = p; hit_p = h; miss_p = m;
        @(posedge clk);
        #1;
        tick = 0; start_p = 0; pause_p = 0; hit_p = 0; miss_p = 0;
    endtask

    initial begin
        rst = 1'b1;
        tick = 0; start_p = 0; pause_p = 0; hit_p = 0; miss_p = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mode", mode, 0);
        chk("rst_score", score, 0);
        chk("rst_digit", count_digit, 0);
        chk("rst_time", time_left, 0);
        chk("rst_active", play_active, 0);

        // Game 1: countdown, play, combo, saturation, pause, finish.
        step(0, 1, 0, 0, 0);
        chk("g1_cd_mode", mode, 3'b010);
        chk("g1_cd3", count_digit, 3);
        step(1, 0, 1, 0, 0);
        chk("g1_cd2", count_digit, 2);
        chk("g1_cd_pause_ign", mode, 3'b010);
        step(1, 0, 0, 0, 0);
        chk("g1_cd1", count_digit, 1);
        step(1, 0, 0, 0, 0);
        chk("g1_play_mode", mode, 3'b011);
        chk("g1_play_time", time_left, 120);
        chk("g1_play_digit", count_digit, 0);
        chk("g1_play_active", play_active, 1);
        repeat (3) step(0, 0, 0, 1, 0);
        chk("g1_3hit_score", score, 3);
        chk("g1_3hit_combo", combo, 3);
        step(0, 0, 0, 1, 1);
        chk("g1_hitmiss_score", score, 3);
        chk("g1_hitmiss_combo", combo, 0);
        repeat (20) step(0, 0, 0, 1, 0);
        chk("g1_sat_score", score, 15);
        chk("g1_sat_combo", combo, 15);
        repeat (70) step(1, 0, 0, 0, 0);
        chk("g1_time50", time_left, 50);
        step(1, 0, 1, 0, 1);
        chk("g1_pause_mode", mode, 3'b100);
        chk("g1_pause_time", time_left, 50);
        chk("g1_pause_combo", combo, 15);
        chk("g1_pause_active", play_active, 0);
        repeat (10) step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("g1_frozen_time", time_left, 50);
        chk("g1_frozen_combo", combo, 15);
        chk("g1_frozen_score", score, 15);
        step(0, 0, 1, 0, 0);
        chk("g1_resume_mode", mode, 3'b011);
        step(1, 0, 0, 0, 0);
        chk("g1_time49", time_left, 49);
        repeat (48) step(1, 0, 0, 0, 0);
        chk("g1_time1", time_left, 1);
        chk("g1_still_play", mode, 3'b011);
        step(1, 0, 0, 0, 0);
        chk("g1_finish_mode", mode, 3'b101);
        chk("g1_finish_time", time_left, 0);
        step(1, 0, 1, 1, 0);
        chk("g1_finish_hold", mode, 3'b101);
        chk("g1_finish_score", score, 15);
        step(0, 1, 0, 0, 0);
        chk("g1_idle_mode", mode, 3'b000);
        chk("g1_idle_score", score, 15);

        // Game 2: bonus behaviour, miss, hit on the final tick.
        step(0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        chk("g2_play_mode", mode, 3'b011);
        chk("g2_score_clr", score, 0);
        chk("g2_combo_clr", combo, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        chk("g2_4hit_score", score, 4);
        step(0, 0, 0, 1, 0);
        chk("g2_5hit_score", score, G2_AFTER5);
        chk("g2_5hit_combo", combo, 5);
        step(0, 0, 0, 0, 1);
        chk("g2_miss_score", score, G2_AFTER5);
        chk("g2_miss_combo", combo, 0);
        repeat (119) step(1, 0, 0, 0, 0);
        chk("g2_time1", time_left, 1);
        step(1, 0, 0, 1, 0);
        chk("g2_final_mode", mode, 3'b101);
        chk("g2_final_score", score, G2_FINAL);
        chk("g2_final_time", time_left, 0);
        step(0, 1, 0, 0, 0);
        chk("g2_idle_mode", mode, 3'b000);
        chk("g2_idle_score", score, G2_FINAL);

        // Game 3: asynchronous reset mid-play.
        step(0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 1, 0);
        chk("g3_score", score, G3_SCORE);
        #2 rst = 1'b1;
        #1;
        chk("g3_arst_mode", mode, 0);
        chk("g3_arst_score", score, 0);
        chk("g3_arst_combo", combo, 0);
        chk("g3_arst_time", time_left, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Game 4: countdown abort, then start+pause in PLAY.
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("g4_abort_mode", mode, 3'b000);
        chk("g4_abort_digit", count_digit, 0);
        step(0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        chk("g4_play_mode", mode, 3'b011);
        step(1, 1, 1, 1, 0);
        chk("g4_startpause_mode", mode, 3'b000);
        chk("g4_startpause_score", score, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
